// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: parses length-prefixed frames from the matched-filter byte
// FIFO, forwards the payload through a 2-entry output buffer and reports a
// per-frame status with an error code.
module rx_frame_ctrl #(
  parameter int unsigned MAX_LEN = 255,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Byte,
  input  logic       pushByte,
  input  logic       Sync,
  input  logic       lastByte,
  output logic       stopin,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic       stat_valid,
  output logic [2:0] stat_err,
  output logic [7:0] stat_len
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 16;
  localparam int unsigned EW = 3;

  localparam logic [EW-1:0] E_OK      = EW'(0);
  localparam logic [EW-1:0] E_SHORT   = EW'(1);
  localparam logic [EW-1:0] E_LONG    = EW'(2);
  localparam logic [EW-1:0] E_RESYNC  = EW'(3);
  localparam logic [EW-1:0] E_TIMEOUT = EW'(4);
  localparam logic [EW-1:0] E_OVF     = EW'(5);
  localparam logic [EW-1:0] E_BADLEN  = EW'(6);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_ERR} state_t;

  state_t        state;
  logic [DW-1:0] frame_len;
  logic [DW-1:0] pcnt;
  logic [TW-1:0] idle_cnt;
  logic          pend_bad;
  logic [CW-1:0] count;
  beat_t         head;
  beat_t         tail;

  beat_t         in_beat;
  logic [DW-1:0] pcnt_inc;
  logic          full;
  logic          pop;
  logic          in_payload;
  logic          last_hit;
  logic          bad_hdr;
  logic          overflow;
  logic          is_hdr;
  logic          push;
  logic          timeout_hit;

  assign out_data = head.data;
  assign out_sof  = head.sof;
  assign out_eof  = head.eof;

  // Backpressure decoded from the registered buffer occupancy.
  assign stopin = (count == CW'(2)) | ((count == CW'(1)) & ~out_ready);

  // Per-cycle classification of the offered byte.
  always_comb begin
    full         = (count == CW'(2));
    pop          = out_valid & out_ready;
    in_payload   = (state == S_PAYLOAD);
    pcnt_inc     = pcnt + DW'(1);
    last_hit     = (pcnt_inc == frame_len);
    bad_hdr      = (Byte == DW'(0)) || (Byte > DW'(MAX_LEN));
    overflow     = pushByte & in_payload & full;
    is_hdr       = pushByte & Sync & ~overflow;
    push         = pushByte & ~Sync & in_payload & ~full;
    in_beat.data = Byte;
    in_beat.sof  = (pcnt == DW'(0));
    in_beat.eof  = lastByte | last_hit;
    timeout_hit  = in_payload & ~pushByte & ((idle_cnt + TW'(1)) == TW'(TIMEOUT));
  end

  // Two-entry output buffer; head drives the stream and only moves on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= CW'(0);
      out_valid <= 1'b0;
    end else if (pop) begin
      if (count == CW'(2)) begin
        head  <= tail;
        count <= CW'(1);
      end else if (push) begin
        head <= in_beat;
      end else begin
        count     <= CW'(0);
        out_valid <= 1'b0;
      end
    end else if (push) begin
      if (count == CW'(0)) begin
        head      <= in_beat;
        count     <= CW'(1);
        out_valid <= 1'b1;
      end else begin
        tail  <= in_beat;
        count <= CW'(2);
      end
    end
  end

  // Frame state machine, idle timer and status reporting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      frame_len  <= DW'(0);
      pcnt       <= DW'(0);
      idle_cnt   <= TW'(0);
      pend_bad   <= 1'b0;
      stat_valid <= 1'b0;
      stat_err   <= E_OK;
      stat_len   <= DW'(0);
    end else begin
      stat_valid <= 1'b0;
      pend_bad   <= 1'b0;
      if (pend_bad) begin
        stat_valid <= 1'b1;
        stat_err   <= E_BADLEN;
        stat_len   <= DW'(0);
      end

      if (pushByte) begin
        idle_cnt <= TW'(0);
      end else if (in_payload) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      case (state)
        S_IDLE, S_ERR: begin
          if (is_hdr) begin
            if (bad_hdr) begin
              state <= S_ERR;
              if (pend_bad) begin
                pend_bad <= 1'b1;
              end else begin
                stat_valid <= 1'b1;
                stat_err   <= E_BADLEN;
                stat_len   <= DW'(0);
              end
            end else begin
              state     <= S_PAYLOAD;
              frame_len <= Byte;
              pcnt      <= DW'(0);
            end
          end else if (pushByte && lastByte && (state == S_ERR)) begin
            state <= S_IDLE;
          end
        end

        S_PAYLOAD: begin
          if (overflow) begin
            stat_valid <= 1'b1;
            stat_err   <= E_OVF;
            stat_len   <= pcnt;
            state      <= S_ERR;
          end else if (is_hdr) begin
            // Aborted frame reports first; a bad new header is reported next cycle.
            stat_valid <= 1'b1;
            stat_err   <= E_RESYNC;
            stat_len   <= pcnt;
            if (bad_hdr) begin
              state    <= S_ERR;
              pend_bad <= 1'b1;
            end else begin
              frame_len <= Byte;
              pcnt      <= DW'(0);
            end
          end else if (push) begin
            pcnt <= pcnt_inc;
            if (lastByte) begin
              stat_valid <= 1'b1;
              stat_err   <= last_hit ? E_OK : E_SHORT;
              stat_len   <= pcnt_inc;
              state      <= S_IDLE;
            end else if (last_hit) begin
              stat_valid <= 1'b1;
              stat_err   <= E_LONG;
              stat_len   <= pcnt_inc;
              state      <= S_ERR;
            end
          end else if (timeout_hit) begin
            stat_valid <= 1'b1;
            stat_err   <= E_TIMEOUT;
            stat_len   <= pcnt;
            state      <= S_IDLE;
            idle_cnt   <= TW'(0);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames plus random traffic against a frame-level
// reference model; expected bytes and statuses are queued and popped by a monitor.
module tb_rx_frame_ctrl;

  localparam int unsigned MAX_LEN = 12;
  localparam int unsigned TIMEOUT = 8;

  localparam int M_IDLE    = 0;
  localparam int M_FRAME   = 1;
  localparam int M_DISCARD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Byte;
  logic       pushByte;
  logic       Sync;
  logic       lastByte;
  logic       stopin;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eof;
  logic       stat_valid;
  logic [2:0] stat_err;
  logic [7:0] stat_len;

  rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .Byte(Byte), .pushByte(pushByte), .Sync(Sync),
    .lastByte(lastByte), .stopin(stopin), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .stat_valid(stat_valid), .stat_err(stat_err), .stat_len(stat_len)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues: {data, sof, eof} and {err, len}.
  logic [9:0]  exp_data[$];
  logic [10:0] exp_stat[$];

  // Reference model state: buffered beats, frame mode, header length, bytes taken, idle gap.
  logic [9:0] mbuf[$];
  int mode = M_IDLE;
  int flen = 0;
  int got  = 0;
  int gap  = 0;
  bit exp_stopin = 1'b0;
  bit exp_valid  = 1'b0;
  bit done       = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void note_stat(input int code, input int len);
    exp_stat.push_back({3'(code), 8'(len)});
  endfunction

  function automatic void take_header(input logic [7:0] b);
    if (b == 8'd0 || int'(b) > int'(MAX_LEN)) begin
      note_stat(6, 0);
      mode = M_DISCARD;
    end else begin
      mode = M_FRAME;
      flen = int'(b);
      got  = 0;
    end
  endfunction

  // Effect of one posedge given the inputs presented to it.
  function automatic void model_step(input bit pb, input bit sy, input bit lb,
                                     input logic [7:0] b, input bit rdy);
    int occ;
    logic [9:0] beat;
    occ = mbuf.size();
    exp_stopin = (occ == 2) || (occ == 1 && !rdy);
    exp_valid  = (occ > 0);
    if (occ > 0 && rdy) void'(mbuf.pop_front());
    if (!pb) begin
      if (mode == M_FRAME) begin
        gap++;
        if (gap == int'(TIMEOUT)) begin
          note_stat(4, got);
          mode = M_IDLE;
          gap  = 0;
        end
      end
    end else begin
      gap = 0;
      if (mode == M_FRAME && occ == 2) begin
        note_stat(5, got);
        mode = M_DISCARD;
      end else if (sy) begin
        if (mode == M_FRAME) note_stat(3, got);
        take_header(b);
      end else if (mode == M_FRAME) begin
        got++;
        beat = {b, (got == 1), (lb || got == flen)};
        mbuf.push_back(beat);
        exp_data.push_back(beat);
        if (lb) begin
          note_stat((got == flen) ? 0 : 1, got);
          mode = M_IDLE;
        end else if (got == flen) begin
          note_stat(2, got);
          mode = M_DISCARD;
        end
      end else if (mode == M_DISCARD && lb) begin
        mode = M_IDLE;
      end
    end
  endfunction

  // One clock of stimulus; honor=1 withholds the byte while stopin is high.
  task automatic cyc(input bit pb, input bit sy, input bit lb, input logic [7:0] b,
                     input bit rdy, input bit honor, output bit taken);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = rdy;
    #1;
    taken    = pb && !(honor && stopin);
    pushByte = taken;
    Sync     = sy;
    lastByte = lb;
    Byte     = b;
    model_step(taken, sy, lb, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit t;
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, rdy, 1'b0, t);
  endtask

  task automatic raw(input bit sy, input bit lb, input logic [7:0] b, input bit rdy);
    bit t;
    cyc(1'b1, sy, lb, b, rdy, 1'b0, t);
  endtask

  task automatic send(input bit sy, input bit lb, input logic [7:0] b);
    bit t;
    t = 1'b0;
    for (int k = 0; k < 50 && !t; k++) cyc(1'b1, sy, lb, b, 1'b1, 1'b1, t);
    if (!t) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_stall: byte %0h not accepted within 50 cycles", b);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stopin"},     32'(stopin),     32'd0);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_out_data"},   32'(out_data),   32'd0);
    check({tag, "_out_sof"},    32'(out_sof),    32'd0);
    check({tag, "_out_eof"},    32'(out_eof),    32'd0);
    check({tag, "_stat_valid"}, 32'(stat_valid), 32'd0);
    check({tag, "_stat_err"},   32'(stat_err),   32'd0);
    check({tag, "_stat_len"},   32'(stat_len),   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    pushByte = 1'b0;
    mbuf.delete();
    exp_data.delete();
    exp_stat.delete();
    mode = M_IDLE;
    gap  = 0;
    #1;
    check_zero("midreset");
  endtask

  // Monitor: compares every handshake and status pulse against the queues.
  initial begin
    logic [9:0]  ed;
    logic [10:0] es;
    forever begin
      @(negedge clk);
      #3;
      if (reset === 1'b1 && !done) begin
        check("stopin", 32'(stopin), 32'(exp_stopin));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid && out_ready) begin
          if (exp_data.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL data_extra: got %0h sof=%b eof=%b, none expected", out_data, out_sof, out_eof);
          end else begin
            ed = exp_data.pop_front();
            check("out_beat", 32'({out_data, out_sof, out_eof}), 32'(ed));
          end
        end
        if (stat_valid) begin
          if (exp_stat.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stat_extra: got err=%0d len=%0d, none expected", stat_err, stat_len);
          end else begin
            es = exp_stat.pop_front();
            check("stat", 32'({stat_err, stat_len}), 32'(es));
          end
        end
      end
    end
  end

  initial begin
    int burst;
    reset     = 1'b0;
    Byte      = 8'h00;
    pushByte  = 1'b0;
    Sync      = 1'b0;
    lastByte  = 1'b0;
    out_ready = 1'b0;
    burst     = 0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("por");

    // Good frame.
    send(1, 0, 8'h03); send(0, 0, 8'hA1); send(0, 0, 8'hB2); send(0, 1, 8'hC3);
    idle(4, 1);

    // Backpressure: fill both entries, then force an extra byte -> overflow.
    raw(1, 0, 8'h03, 0); raw(0, 0, 8'hA1, 0); raw(0, 0, 8'hB2, 0); raw(0, 1, 8'hC3, 0);
    idle(6, 0); idle(4, 1);
    // Backpressure without loss: buffer full, then released.
    raw(1, 0, 8'h03, 0); raw(0, 0, 8'hA1, 0); raw(0, 0, 8'hB2, 0);
    idle(5, 0);
    send(0, 1, 8'hC3);
    idle(4, 1);

    // Short frame, then long frame with trailing bytes discarded.
    send(1, 0, 8'h04); send(0, 0, 8'h10); send(0, 1, 8'h11);
    send(1, 0, 8'h02); send(0, 0, 8'h20); send(0, 0, 8'h21);
    send(0, 0, 8'h22); send(0, 0, 8'h23);
    send(1, 0, 8'h01); send(0, 1, 8'h5A);
    idle(3, 1);

    // Resync with a zero header, then bad length, then a maximum-length frame.
    send(1, 0, 8'h05); send(0, 0, 8'h30); send(0, 0, 8'h31); send(1, 0, 8'h00);
    send(0, 0, 8'h77);
    send(1, 0, 8'(MAX_LEN + 1));
    send(1, 0, 8'(MAX_LEN));
    for (int k = 1; k <= int'(MAX_LEN); k++) send(0, (k == int'(MAX_LEN)), 8'(k + 8'h40));
    idle(3, 1);

    // Idle gap one short of the timeout, then a full timeout gap.
    send(1, 0, 8'h03); send(0, 0, 8'h11);
    idle(TIMEOUT - 1, 1);
    send(0, 0, 8'h22);
    idle(TIMEOUT + 2, 1);
    send(0, 1, 8'h33);

    // Reset mid-frame, then a clean frame.
    send(1, 0, 8'h04); send(0, 0, 8'h44);
    do_reset();
    send(1, 0, 8'h03); send(0, 0, 8'hA1); send(0, 0, 8'hB2); send(0, 1, 8'hC3);
    idle(4, 1);

    // Random traffic with occasional long gaps and stopin violations.
    for (int i = 0; i < 3000; i++) begin
      bit pb, sy, lb, rdy, hon, t;
      logic [7:0] b;
      if (burst > 0) begin
        burst--;
        pb = 1'b0;
      end else begin
        pb = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(5, 11);
      end
      sy  = ($urandom_range(0, 9) == 0);
      lb  = ($urandom_range(0, 99) < 15);
      b   = sy ? 8'($urandom_range(0, MAX_LEN + 2)) : 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      hon = ($urandom_range(0, 7) != 0);
      cyc(pb, sy, lb, b, rdy, hon, t);
    end

    idle(40, 1);
    @(negedge clk);
    #4;
    done = 1'b1;
    check("data_left", 32'(exp_data.size()), 32'd0);
    check("stat_left", 32'(exp_stat.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
